// File: rtl/data_memory_responder.sv
// Data-memory responder: little-endian byte-addressed RAM behind valid/ready request and response
// channels with programmable wait latency. Define DMEM_ACCESS_CNT_EN to add rd_count/wr_count.
module data_memory_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH_BYTES);
    localparam int unsigned WORDS = DEPTH_BYTES / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [3:0]  wait_cnt;
    logic        we_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;

    // Stored as 64-bit words: an aligned access never straddles a word.
    logic [63:0] mem [WORDS];

    logic          accept;
    logic          access;
    logic [3:0]    nbytes;
    logic [64:0]   last_addr;
    logic          misaligned;
    logic          out_of_range;
    logic          acc_err;
    logic [AW-4:0] word_idx;
    logic [5:0]    lane_shift;
    logic [63:0]   lane_mask;
    logic [63:0]   word_rd;
    logic [63:0]   raw;
    logic [63:0]   load_data;

    // Access decode on the latched request; range check is done on a 65-bit sum so it cannot wrap.
    always_comb begin
        nbytes       = 4'd1 << size_q;
        last_addr    = {1'b0, addr_q} + {61'd0, nbytes} - 65'd1;
        misaligned   = (addr_q[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
        out_of_range = last_addr >= 65'(DEPTH_BYTES);
        acc_err      = misaligned | out_of_range;
        word_idx     = addr_q[AW-1:3];
        lane_shift   = {addr_q[2:0], 3'b000};
        case (size_q)
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        word_rd = mem[word_idx];
        raw     = word_rd >> lane_shift;
        case (size_q)
            2'b00:   load_data = unsigned_q ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'b01:   load_data = unsigned_q ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'b10:   load_data = unsigned_q ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: load_data = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                unsigned_q <= req_unsigned;
                size_q     <= req_size;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                wait_cnt   <= 4'(LATENCY);
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || we_q) ? 64'd0 : load_data;
            end
        end
    end

    // NOTE: RAM has no reset; rst only blocks a write so a dropped transaction leaves memory untouched.
    always_ff @(posedge clk) begin
        if (!rst && access && we_q && !acc_err)
            mem[word_idx] <= (word_rd & ~(lane_mask << lane_shift)) |
                             ((wdata_q & lane_mask) << lane_shift);
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (access && !acc_err) begin
            if (we_q) wr_count <= wr_count + 32'd1;
            else      rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: stimulus pushes expected responses, a negedge
// monitor pops and compares each accepted response; timing and reset behaviour checked inline.
module tb_data_memory_responder;

    localparam int unsigned LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    data_memory_responder #(.DEPTH_BYTES(1024), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_ACCESS_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    typedef struct {
        int          id;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed on the edge following a negedge with rsp_valid && rsp_ready.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rdata 0x%016h err %0b, expected no response",
                         rsp_rdata, rsp_err);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("rsp%0d rdata", mon_e.id), rsp_rdata, mon_e.rdata);
                check($sformatf("rsp%0d err", mon_e.id), 64'(rsp_err), 64'(mon_e.err));
            end
        end
    end

    task automatic push(input logic [63:0] rdata, input logic err, input logic we);
        exp_t e;
        e.id    = n_push;
        e.rdata = rdata;
        e.err   = err;
        n_push++;
        sb.push_back(e);
        if (!err) begin
            if (we) exp_wr++;
            else    exp_rd++;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
    endtask

    // Waits for req_ready, lets the accept edge pass, then scrambles the inputs.
    task automatic accept(input string name);
        int k   = 0;
        bit got = 1'b0;
        while (k < 40 && !got) begin
            @(negedge clk);
            if (req_ready) got = 1'b1;
            k++;
        end
        check({name, " accepted"}, 64'(got), 64'd1);
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = ~req_we;
        req_size     = ~req_size;
        req_unsigned = ~req_unsigned;
        req_addr     = ~req_addr;
        req_wdata    = ~req_wdata;
    endtask

    // Called just after the accept edge: counts cycles until rsp_valid.
    task automatic finish_rsp(input string name);
        int k          = 0;
        bit ready_high = 1'b0;
        while (k < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (req_ready) ready_high = 1'b1;
            k++;
        end
        check({name, " latency"}, 64'(k), 64'(LATENCY + 1));
        check({name, " req_ready low"}, 64'(ready_high), 64'd0);
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err);
        push(exp_rdata, exp_err, we);
        drive(we, size, uns, addr, wdata);
        accept(name);
        finish_rsp(name);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        exp_rd    = 0;
        exp_wr    = 0;
    endtask

    task automatic check_reset(input string name);
        check({name, " req_ready"}, 64'(req_ready), 64'd1);
        check({name, " rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({name, " rsp_rdata"}, rsp_rdata, 64'd0);
        check({name, " rsp_err"}, 64'(rsp_err), 64'd0);
`ifdef DMEM_ACCESS_CNT_EN
        check({name, " rd_count"}, 64'(rd_count), 64'd0);
        check({name, " wr_count"}, 64'(wr_count), 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("reset");

        // Known background so untouched lanes have defined contents.
        do_req("init30", 1, 2'b11, 0, 64'h30, 64'h0, 64'h0, 0);
        do_req("init20", 1, 2'b11, 0, 64'h20, 64'h0, 64'h0, 0);

        do_req("st_w30",  1, 2'b10, 0, 64'h30, 64'hFFFF_FFFF_AABB_CCDD, 64'h0, 0);
        do_req("ld_w30s", 0, 2'b10, 0, 64'h30, 64'h0, 64'hFFFF_FFFF_AABB_CCDD, 0);
        do_req("ld_b30s", 0, 2'b00, 0, 64'h30, 64'h0, 64'hFFFF_FFFF_FFFF_FFDD, 0);
        do_req("ld_h32u", 0, 2'b01, 1, 64'h32, 64'h0, 64'h0000_0000_0000_AABB, 0);
        do_req("st_b31",  1, 2'b00, 0, 64'h31, 64'hDEAD_BEEF_CAFE_0011, 64'h0, 0);
        do_req("ld_d30",  0, 2'b11, 1, 64'h30, 64'h0, 64'h0000_0000_AABB_11DD, 0);
        do_req("ld_b31s", 0, 2'b00, 0, 64'h31, 64'h0, 64'h0000_0000_0000_0011, 0);

        do_req("st_h20",    1, 2'b01, 0, 64'h20, 64'h0000_0000_0000_1234, 64'h0, 0);
        do_req("st_h21_mis", 1, 2'b01, 0, 64'h21, 64'h0000_0000_0000_BEEF, 64'h0, 1);
        do_req("ld_h20s",   0, 2'b01, 0, 64'h20, 64'h0, 64'h0000_0000_0000_1234, 0);
        do_req("ld_w32_mis", 0, 2'b10, 1, 64'h32, 64'h0, 64'h0, 1);
        do_req("ld_b400",   0, 2'b00, 1, 64'h400, 64'h0, 64'h0, 1);
        do_req("ld_b_top",  0, 2'b00, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1);

        do_req("st_d3f8",  1, 2'b11, 0, 64'h3F8, 64'h8877_6655_4433_2211, 64'h0, 0);
        do_req("ld_w3fcs", 0, 2'b10, 0, 64'h3FC, 64'h0, 64'hFFFF_FFFF_8877_6655, 0);
        do_req("ld_d3f8",  0, 2'b11, 0, 64'h3F8, 64'h0, 64'h8877_6655_4433_2211, 0);
        do_req("ld_h3fes", 0, 2'b01, 0, 64'h3FE, 64'h0, 64'hFFFF_FFFF_FFFF_8877, 0);
        do_req("ld_w3fe_mis", 0, 2'b10, 0, 64'h3FE, 64'h0, 64'h0, 1);

        // Back-pressure: response held, queued request waits for IDLE.
        rsp_ready = 1'b0;
        push(64'h0000_0000_AABB_11DD, 0, 0);
        drive(0, 2'b10, 1, 64'h30, 64'h0);
        accept("stall_ld");
        finish_rsp("stall_ld");
        push(64'h0000_0000_0000_00AA, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) drive(0, 2'b00, 1, 64'h33, 64'h0);
            @(negedge clk);
            check("stall rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall rsp_rdata", rsp_rdata, 64'h0000_0000_AABB_11DD);
            check("stall req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("reentry req_ready", 64'(req_ready), 64'd1);
        check("reentry rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        check("queued accepted", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        finish_rsp("queued_ld");

        // Reset during WAIT drops the store.
        do_req("st_b40", 1, 2'b00, 0, 64'h40, 64'h0000_0000_0000_009A, 64'h0, 0);
        drive(1, 2'b00, 0, 64'h40, 64'h0000_0000_0000_0055);
        accept("st_b40_drop");
        @(negedge clk);
        pulse_reset();
        check_reset("rst_wait");
        do_req("ld_b40", 0, 2'b00, 1, 64'h40, 64'h0, 64'h0000_0000_0000_009A, 0);

        // Reset during RESP keeps the completed store.
        rsp_ready = 1'b0;
        drive(1, 2'b00, 0, 64'h48, 64'h0000_0000_0000_0077);
        accept("st_b48");
        finish_rsp("st_b48");
        pulse_reset();
        check_reset("rst_resp");
        do_req("ld_b48", 0, 2'b00, 1, 64'h48, 64'h0, 64'h0000_0000_0000_0077, 0);
        do_req("st_b49", 1, 2'b00, 0, 64'h49, 64'h0000_0000_0000_0001, 64'h0, 0);
        do_req("st_b4a_oor", 1, 2'b00, 0, 64'h1_0000_004A, 64'h0, 64'h0, 1);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
`ifdef DMEM_ACCESS_CNT_EN
        check("rd_count", 64'(rd_count), 64'(exp_rd));
        check("wr_count", 64'(wr_count), 64'(exp_wr));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
